// File: rtl/immunity_sopc_bus_if.sv
// rtl/immunity_sopc_bus_if.sv - core-side and slave-side signal bundle of the Immunity data bus.
interface immunity_sopc_bus_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4
);

  logic                       m_en;
  logic                       m_write_en;
  logic [DATA_W/8-1:0]        m_write_sel;
  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_write_data;
  logic [DATA_W-1:0]          m_read_data;
  logic                       m_stall;
  logic                       m_err;

  logic [N_SLAVES-1:0]        s_en;
  logic                       s_write_en;
  logic [DATA_W/8-1:0]        s_write_sel;
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_write_data;
  logic [N_SLAVES*DATA_W-1:0] s_read_data;
  logic [N_SLAVES-1:0]        s_ready;

  // The interconnect: takes core requests and slave responses, drives the rest.
  modport master (
    input  m_en, m_write_en, m_write_sel, m_addr, m_write_data,
    input  s_read_data, s_ready,
    output m_read_data, m_stall, m_err,
    output s_en, s_write_en, s_write_sel, s_addr, s_write_data
  );

  modport slave (
    output m_en, m_write_en, m_write_sel, m_addr, m_write_data,
    output s_read_data, s_ready,
    input  m_read_data, m_stall, m_err,
    input  s_en, s_write_en, s_write_sel, s_addr, s_write_data
  );

endinterface

// File: rtl/immunity_sopc_bus.sv
// rtl/immunity_sopc_bus.sv - address-decoded core-to-N-slave data bus with stall and error response.
// Define IMMUNITY_BUS_TIMEOUT_EN to compile in the BUSY timeout counter.
module immunity_sopc_bus #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 2,
  parameter int N_SLAVES = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  immunity_sopc_bus_if.master    io_bus
);

  localparam int BYTES_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [SEL_W-1:0]    w_idx;
  logic                w_decode_ok;
  logic                w_ready;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_slave_rdata;
  logic [N_SLAVES-1:0] w_s_en;
  logic                w_stall;

  logic [SEL_W-1:0]    r_idx;
  logic                r_write_en;
  logic [BYTES_W-1:0]  r_write_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_write_data;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_err;

  assign w_idx       = io_bus.m_addr[ADDR_W-1 -: SEL_W];
  assign w_decode_ok = (int'(w_idx) < N_SLAVES);

  // Only the captured slave's ready/data matter; the rest are ignored.
  always_comb begin
    w_ready       = 1'b0;
    w_slave_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_idx == SEL_W'(k)) begin
        w_ready       = io_bus.s_ready[k];
        w_slave_rdata = io_bus.s_read_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef IMMUNITY_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Cleared in IDLE so every BUSY entry starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_ready;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT < 2);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (io_bus.m_en) begin
          w_next = w_decode_ok ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (w_ready || w_timeout) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // s_en decodes straight from the state, so an async reset drops it at once.
  always_comb begin
    w_s_en  = '0;
    w_stall = 1'b0;
    case (r_state)
      IDLE: w_stall = io_bus.m_en;
      BUSY: begin
        w_stall = 1'b1;
        for (int k = 0; k < N_SLAVES; k++) begin
          w_s_en[k] = (r_idx == SEL_W'(k));
        end
      end
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_write_en   <= 1'b0;
      r_write_sel  <= '0;
      r_addr       <= '0;
      r_write_data <= '0;
      r_read_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.m_en) begin
            r_idx        <= w_idx;
            r_write_en   <= io_bus.m_write_en;
            r_write_sel  <= io_bus.m_write_sel;
            r_addr       <= io_bus.m_addr;
            r_write_data <= io_bus.m_write_data;
            if (!w_decode_ok) begin
              r_err <= 1'b1;
              if (!io_bus.m_write_en) begin
                r_read_data <= '1;
              end
            end
          end
        end
        BUSY: begin
          if (w_ready) begin
            if (!r_write_en) begin
              r_read_data <= w_slave_rdata;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_write_en) begin
              r_read_data <= '1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.s_en         = w_s_en;
  assign io_bus.s_write_en   = r_write_en;
  assign io_bus.s_write_sel  = r_write_sel;
  assign io_bus.s_addr       = r_addr;
  assign io_bus.s_write_data = r_write_data;
  assign io_bus.m_read_data  = r_read_data;
  assign io_bus.m_stall      = w_stall;
  assign io_bus.m_err        = r_err;

endmodule

// File: tb/tb_immunity_sopc_bus.sv
// tb/tb_immunity_sopc_bus.sv - scoreboard bench for immunity_sopc_bus (4-slave and 3-slave builds).
module tb_immunity_sopc_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] model_rd;

  immunity_sopc_bus_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4)) bus_a ();
  immunity_sopc_bus_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3)) bus_b ();

  immunity_sopc_bus #(.ADDR_W(32), .DATA_W(32), .SEL_W(2), .N_SLAVES(4), .TIMEOUT(16)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_a)
  );

  immunity_sopc_bus #(.ADDR_W(32), .DATA_W(32), .SEL_W(2), .N_SLAVES(3), .TIMEOUT(16)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus_a.m_en = 1'b0; bus_a.m_write_en = 1'b0; bus_a.m_write_sel = '0;
    bus_a.m_addr = '0; bus_a.m_write_data = '0; bus_a.s_read_data = '0; bus_a.s_ready = '0;
    bus_b.m_en = 1'b0; bus_b.m_write_en = 1'b0; bus_b.m_write_sel = '0;
    bus_b.m_addr = '0; bus_b.m_write_data = '0; bus_b.s_read_data = '0; bus_b.s_ready = '0;
  endtask

  task automatic drive_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel);
    bus_a.m_en = 1'b1; bus_a.m_write_en = we; bus_a.m_addr = addr;
    bus_a.m_write_data = wdata; bus_a.m_write_sel = sel;
  endtask

  task automatic test_reset;
    idle_inputs();
    tick(); tick();
    checks++; if (bus_a.m_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus_a.m_read_data); end
    checks++; if (bus_a.m_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_a.m_err); end
    checks++; if (bus_a.s_en !== 4'b0) begin errors++; $display("FAIL reset_s_en: got %b want 0", bus_a.s_en); end
    checks++; if ({bus_a.s_write_en, bus_a.s_write_sel, bus_a.s_addr, bus_a.s_write_data} !== 69'h0) begin
      errors++; $display("FAIL reset_s_bus: we=%b sel=%b addr=%h wd=%h want all 0", bus_a.s_write_en, bus_a.s_write_sel, bus_a.s_addr, bus_a.s_write_data);
    end
    checks++; if (bus_a.m_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b want 0", bus_a.m_stall); end
    bus_a.m_en = 1'b1;
    #1;
    checks++; if (bus_a.m_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follow: got %b want 1", bus_a.m_stall); end
    bus_a.m_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    model_rd = 32'h0;
  endtask

  task automatic test_single_read;
    bus_a.s_read_data = '0;
    bus_a.s_read_data[1*32 +: 32] = 32'hDEAD_BEEF;
    bus_a.s_ready = 4'b0010;
    drive_a(1'b0, 32'h4000_0010, 32'h0, 4'hF);
    model_rd = 32'hDEAD_BEEF;
    exp_q.push_back(model_rd);
    #1;
    checks++; if (bus_a.m_stall !== 1'b1) begin errors++; $display("FAIL single_stall_c0: got %b want 1", bus_a.m_stall); end
    tick();
    checks++; if (bus_a.s_en !== 4'b0010) begin errors++; $display("FAIL single_s_en_c1: got %b want 0010", bus_a.s_en); end
    checks++; if (bus_a.m_stall !== 1'b1) begin errors++; $display("FAIL single_stall_c1: got %b want 1", bus_a.m_stall); end
    tick();
    checks++; if (bus_a.m_stall !== 1'b0) begin errors++; $display("FAIL single_stall_c2: got %b want 0", bus_a.m_stall); end
    checks++; if (bus_a.m_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", bus_a.m_err); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL single_rdata: scoreboard empty, got %h", bus_a.m_read_data); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus_a.m_read_data !== exp_v) begin errors++; $display("FAIL single_rdata: got %h want %h", bus_a.m_read_data, exp_v); end
    end
    bus_a.m_en = 1'b0; bus_a.s_ready = '0;
    tick();
  endtask

  task automatic test_write_latency;
    int good;
    good = 0;
    bus_a.s_ready = 4'b0111;
    drive_a(1'b1, 32'hC000_0004, 32'h0000_AB00, 4'b0010);
    exp_q.push_back(model_rd);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) bus_a.s_ready = 4'b1111;
      if (bus_a.s_en === 4'b1000 && bus_a.s_write_en === 1'b1 && bus_a.s_write_sel === 4'b0010 &&
          bus_a.s_write_data === 32'h0000_AB00 && bus_a.s_addr === 32'hC000_0004 && bus_a.m_stall === 1'b1)
        good++;
      tick();
    end
    checks++; if (good !== 3) begin errors++; $display("FAIL write_busy_stable: got %0d good BUSY cycles want 3", good); end
    checks++; if (bus_a.m_stall !== 1'b0) begin errors++; $display("FAIL write_done_c4: stall got %b want 0", bus_a.m_stall); end
    checks++; if (bus_a.m_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b want 0", bus_a.m_err); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL write_rdata: scoreboard empty, got %h", bus_a.m_read_data); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus_a.m_read_data !== exp_v) begin errors++; $display("FAIL write_rdata: got %h want %h", bus_a.m_read_data, exp_v); end
    end
    bus_a.m_en = 1'b0; bus_a.s_ready = '0;
    tick();
  endtask

  task automatic test_timeout;
    int busy;
    busy = 0;
    bus_a.s_read_data = '0;
    bus_a.s_read_data[2*32 +: 32] = 32'h1234_5678;
    bus_a.s_ready = 4'b1011;
    drive_a(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    tick();
`ifdef IMMUNITY_BUS_TIMEOUT_EN
    model_rd = 32'hFFFF_FFFF;
    exp_q.push_back(model_rd);
    for (int c = 1; c <= 16; c++) begin
      if (bus_a.s_en === 4'b0100 && bus_a.m_stall === 1'b1) busy++;
      tick();
    end
    checks++; if (busy !== 16) begin errors++; $display("FAIL timeout_busy_cycles: got %0d want 16", busy); end
    checks++; if (bus_a.m_stall !== 1'b0) begin errors++; $display("FAIL timeout_done_stall: got %b want 0", bus_a.m_stall); end
    checks++; if (bus_a.m_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", bus_a.m_err); end
`else
    for (int c = 1; c <= 100; c++) begin
      if (bus_a.s_en === 4'b0100 && bus_a.m_stall === 1'b1) busy++;
      tick();
    end
    checks++; if (busy !== 100 || bus_a.m_stall !== 1'b1) begin
      errors++; $display("FAIL no_timeout_stall: busy cycles %0d stall %b want 100 and 1", busy, bus_a.m_stall);
    end
    bus_a.s_ready = 4'b1111;
    model_rd = 32'h1234_5678;
    exp_q.push_back(model_rd);
    tick();
    checks++; if (bus_a.m_err !== 1'b0) begin errors++; $display("FAIL late_ready_err: got %b want 0", bus_a.m_err); end
`endif
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL timeout_rdata: scoreboard empty, got %h", bus_a.m_read_data); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus_a.m_read_data !== exp_v) begin errors++; $display("FAIL timeout_rdata: got %h want %h", bus_a.m_read_data, exp_v); end
    end
    bus_a.m_en = 1'b0; bus_a.s_ready = '0;
    tick();
  endtask

  task automatic test_decode_error;
    bus_b.s_ready = 3'b111;
    bus_b.m_en = 1'b1; bus_b.m_write_en = 1'b0; bus_b.m_addr = 32'hC000_0000; bus_b.m_write_sel = 4'hF;
    #1;
    checks++; if (bus_b.m_stall !== 1'b1 || bus_b.s_en !== 3'b000) begin
      errors++; $display("FAIL decode_c0: stall %b s_en %b want 1 000", bus_b.m_stall, bus_b.s_en);
    end
    tick();
    checks++; if (bus_b.s_en !== 3'b000) begin errors++; $display("FAIL decode_s_en: got %b want 000", bus_b.s_en); end
    checks++; if (bus_b.m_err !== 1'b1) begin errors++; $display("FAIL decode_err: got %b want 1", bus_b.m_err); end
    checks++; if (bus_b.m_stall !== 1'b0) begin errors++; $display("FAIL decode_stall: got %b want 0", bus_b.m_stall); end
    checks++; if (bus_b.m_read_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL decode_rdata: got %h want ffffffff", bus_b.m_read_data); end
    bus_b.m_en = 1'b0; bus_b.s_ready = '0;
    tick();
    checks++; if (bus_b.m_err !== 1'b0 || bus_b.s_en !== 3'b000) begin
      errors++; $display("FAIL decode_after: err %b s_en %b want 0 000", bus_b.m_err, bus_b.s_en);
    end
  endtask

  task automatic test_reset_mid_busy;
    bus_a.s_read_data = '0;
    bus_a.s_read_data[0 +: 32] = 32'h55AA_55AA;
    bus_a.s_ready = '0;
    drive_a(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    checks++; if (bus_a.s_en !== 4'b0001) begin errors++; $display("FAIL midrst_busy_s_en: got %b want 0001", bus_a.s_en); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_a.s_en !== 4'b0000) begin errors++; $display("FAIL midrst_s_en: got %b want 0000", bus_a.s_en); end
    checks++; if (bus_a.m_read_data !== 32'h0 || bus_a.m_err !== 1'b0) begin
      errors++; $display("FAIL midrst_resp: rdata %h err %b want 0 0", bus_a.m_read_data, bus_a.m_err);
    end
    checks++; if ({bus_a.s_write_en, bus_a.s_write_sel, bus_a.s_addr, bus_a.s_write_data} !== 69'h0) begin
      errors++; $display("FAIL midrst_s_bus: we=%b sel=%b addr=%h wd=%h want all 0", bus_a.s_write_en, bus_a.s_write_sel, bus_a.s_addr, bus_a.s_write_data);
    end
    checks++; if (bus_a.m_stall !== 1'b1) begin errors++; $display("FAIL midrst_stall: got %b want 1", bus_a.m_stall); end
    bus_a.m_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    model_rd = 32'h0;
    test_single_read();
  endtask

  task automatic test_back_to_back;
    bus_a.s_read_data = '0;
    bus_a.s_read_data[0*32 +: 32] = 32'hA5A5_0000;
    bus_a.s_read_data[1*32 +: 32] = 32'h0BAD_F00D;
    bus_a.s_ready = 4'b0011;
    drive_a(1'b0, 32'h0000_0004, 32'h0, 4'hF);
    model_rd = 32'hA5A5_0000;
    exp_q.push_back(model_rd);
    tick();
    checks++; if (bus_a.s_en !== 4'b0001 || bus_a.s_addr !== 32'h0000_0004) begin
      errors++; $display("FAIL b2b_first_busy: s_en %b addr %h want 0001 00000004", bus_a.s_en, bus_a.s_addr);
    end
    tick();
    checks++; if (bus_a.m_stall !== 1'b0) begin errors++; $display("FAIL b2b_first_done: stall %b want 0", bus_a.m_stall); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_first_rdata: scoreboard empty, got %h", bus_a.m_read_data); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus_a.m_read_data !== exp_v) begin errors++; $display("FAIL b2b_first_rdata: got %h want %h", bus_a.m_read_data, exp_v); end
    end
    drive_a(1'b0, 32'h4000_0008, 32'h0, 4'hF);
    model_rd = 32'h0BAD_F00D;
    exp_q.push_back(model_rd);
    tick();
    checks++; if (bus_a.s_en !== 4'b0000 || bus_a.m_stall !== 1'b1) begin
      errors++; $display("FAIL b2b_c3_idle: s_en %b stall %b want 0000 1", bus_a.s_en, bus_a.m_stall);
    end
    tick();
    checks++; if (bus_a.s_en !== 4'b0010 || bus_a.s_addr !== 32'h4000_0008) begin
      errors++; $display("FAIL b2b_second_busy: s_en %b addr %h want 0010 40000008", bus_a.s_en, bus_a.s_addr);
    end
    tick();
    checks++; if (bus_a.m_stall !== 1'b0) begin errors++; $display("FAIL b2b_second_done_c5: stall %b want 0", bus_a.m_stall); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_second_rdata: scoreboard empty, got %h", bus_a.m_read_data); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus_a.m_read_data !== exp_v) begin errors++; $display("FAIL b2b_second_rdata: got %h want %h", bus_a.m_read_data, exp_v); end
    end
    bus_a.m_en = 1'b0;
    tick();
    checks++; if (bus_a.s_en !== 4'b0000 || bus_a.m_stall !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_after: s_en %b stall %b pending %0d want 0000 0 0", bus_a.s_en, bus_a.m_stall, exp_q.size());
    end
    bus_a.s_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_latency();
    test_timeout();
    test_decode_error();
    test_reset_mid_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
